// File: rtl/spi_master_gen_if.sv
// Controller- and pad-side signals of spi_master_gen; cs_hold exists only with SPI_CS_HOLD_EN.
// Modport master is the SPI engine, modport slave is the controller/pad side driving it.
interface spi_master_gen_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [CS_W-1:0]   cs_sel;
`ifdef SPI_CS_HOLD_EN
    logic              cs_hold;
`endif
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              sd_clk;
    logic              sd_in;
    logic              sd_out;
    logic [NUM_CS-1:0] sd_cs;

`ifdef SPI_CS_HOLD_EN
    modport master (
        input  start, data_in, cs_sel, cs_hold, sd_out,
        output data_out, busy, done, sd_clk, sd_in, sd_cs
    );
    modport slave (
        output start, data_in, cs_sel, cs_hold, sd_out,
        input  data_out, busy, done, sd_clk, sd_in, sd_cs
    );
`else
    modport master (
        input  start, data_in, cs_sel, sd_out,
        output data_out, busy, done, sd_clk, sd_in, sd_cs
    );
    modport slave (
        output start, data_in, cs_sel, sd_out,
        input  data_out, busy, done, sd_clk, sd_in, sd_cs
    );
`endif
endinterface

// File: rtl/spi_master_gen.sv
// Full-duplex SPI master, all CPOL/CPHA modes; done (2*DATA_W+2)*CLK_DIV+1 cycles after start, optional SPI_CS_HOLD_EN.
// No backpressure: start is honoured only while busy=0 and is otherwise dropped, never queued.
module spi_master_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input logic              clk,
    input logic              rst,
    spi_master_gen_if.master bus
);
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [TOG_W-1:0]  tog;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] dout;
    logic [NUM_CS-1:0] cs_n;
    logic              sclk;
    logic              mosi;
    logic              busy_q;
    logic              done_q;
`ifdef SPI_CS_HOLD_EN
    logic              hold_lat;
    logic              held;
    logic [CS_W-1:0]   held_sel;
`endif

    logic cnt_tc;
    logic tog_last;
    assign cnt_tc   = (cnt == CNT_W'(CLK_DIV - 1));
    assign tog_last = (tog == TOG_W'(2 * DATA_W - 1));

    // An out-of-range index matches no line, so every CS stays high.
    function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_W-1:0] s);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (s == CS_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            tog    <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            dout   <= '0;
            cs_n   <= '1;
            sclk   <= CPOL;
            mosi   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SPI_CS_HOLD_EN
            hold_lat <= 1'b0;
            held     <= 1'b0;
            held_sel <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high in the done cycle, which blocks a back-to-back start.
                    if (!busy_q && bus.start) begin
                        tx_sr  <= bus.data_in;
                        cs_n   <= cs_mask(bus.cs_sel);
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        tog    <= '0;
                        state  <= LEAD;
                        if (CPHA == 1'b0) mosi <= bus.data_in[DATA_W-1];
`ifdef SPI_CS_HOLD_EN
                        hold_lat <= bus.cs_hold;
                        held     <= 1'b0;
                        held_sel <= bus.cs_sel;
                        if (held && (bus.cs_sel == held_sel)) state <= XFER;
`endif
                    end else begin
                        busy_q <= 1'b0;
`ifdef SPI_CS_HOLD_EN
                        if (held && !bus.cs_hold) begin
                            cs_n <= '1;
                            held <= 1'b0;
                        end
`endif
                    end
                end
                LEAD: begin
                    if (cnt_tc) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (cnt_tc) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        tog  <= tog + 1'b1;
                        // tog counts completed toggles, so an even count means this one is leading.
                        if (tog[0] == 1'b0) begin
                            if (CPHA == 1'b0) begin
                                rx_sr <= {rx_sr[DATA_W-2:0], bus.sd_out};
                            end else begin
                                mosi  <= tx_sr[DATA_W-1];
                                tx_sr <= tx_sr << 1;
                            end
                        end else begin
                            if (CPHA == 1'b0) begin
                                if (!tog_last) begin
                                    mosi  <= tx_sr[DATA_W-2];
                                    tx_sr <= tx_sr << 1;
                                end
                            end else begin
                                rx_sr <= {rx_sr[DATA_W-2:0], bus.sd_out};
                            end
                        end
                        if (tog_last) state <= TRAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (cnt_tc) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        done_q <= 1'b1;
                        dout   <= rx_sr;
                        mosi   <= 1'b1;
`ifdef SPI_CS_HOLD_EN
                        if (hold_lat) held <= 1'b1;
                        else          cs_n <= '1;
`else
                        cs_n   <= '1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sd_clk   = sclk;
    assign bus.sd_in    = mosi;
    assign bus.sd_cs    = cs_n;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = dout;
endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench: mode 0 loopback on a 4-CS master and mode 3 with a slave model on a 3-CS master.
// Covers reset, CS decode, ignored restart, mid-transfer reset and (with SPI_CS_HOLD_EN) CS hold.
module tb_spi_master_gen;
    logic clk = 1'b0;
    logic rst;
    logic hold0;
    logic slv_miso = 1'b1;
    logic [7:0] slv_tx;
    logic [7:0] slv_rx;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_master_gen_if #(.DATA_W(8), .NUM_CS(4)) bus0 ();
    spi_master_gen_if #(.DATA_W(8), .NUM_CS(3)) bus3 ();

    spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );
    spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(3), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.master)
    );

    assign bus0.sd_out = bus0.sd_in;
    assign bus3.sd_out = slv_miso;
`ifdef SPI_CS_HOLD_EN
    assign bus0.cs_hold = hold0;
    assign bus3.cs_hold = 1'b0;
`endif

    // Mode 3 slave: drive on the falling (leading) edge, capture on the rising (trailing) edge.
    always @(negedge bus3.sd_clk) begin
        if (bus3.sd_cs[0] == 1'b0) begin
            slv_miso = slv_tx[7];
            slv_tx   = {slv_tx[6:0], 1'b0};
        end
    end
    always @(posedge bus3.sd_clk) begin
        if (bus3.sd_cs[0] == 1'b0) slv_rx = {slv_rx[6:0], bus3.sd_in};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run0(input logic [7:0] d, input logic [1:0] sel, input logic hold, input bit mid,
                        input int exp_done, input logic [3:0] exp_cs, input logic [3:0] exp_after,
                        input string tag);
        int   done_at = 0;
        int   ndone   = 0;
        int   tog     = 0;
        int   cs_bad  = 0;
        logic prev_clk;
        check({tag, "_idle_clk"}, 32'(bus0.sd_clk), 32'd0);
        bus0.data_in = d;
        bus0.cs_sel  = sel;
        hold0        = hold;
        bus0.start   = 1'b1;
        prev_clk     = bus0.sd_clk;
        for (int n = 1; n <= exp_done + 2; n++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (mid && n == 15) begin
                bus0.start   = 1'b1;
                bus0.data_in = 8'hFF;
                bus0.cs_sel  = 2'd3;
            end
            if (n == 1) check({tag, "_busy_c1"}, 32'(bus0.busy), 32'd1);
            if (bus0.done) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (bus0.sd_clk !== prev_clk) tog++;
            prev_clk = bus0.sd_clk;
            if (n < exp_done && bus0.sd_cs !== exp_cs) cs_bad++;
        end
        check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_toggles"}, 32'(tog), 32'd16);
        check({tag, "_cs_during"}, 32'(cs_bad), 32'd0);
        check({tag, "_data_out"}, 32'(bus0.data_out), 32'(d));
        check({tag, "_clk_after"}, 32'(bus0.sd_clk), 32'd0);
        check({tag, "_cs_after"}, 32'(bus0.sd_cs), 32'(exp_after));
        check({tag, "_busy_after"}, 32'(bus0.busy), 32'd0);
        check({tag, "_mosi_after"}, 32'(bus0.sd_in), 32'd1);
    endtask

    task automatic run3(input logic [7:0] d, input logic [1:0] sel, input logic [2:0] exp_cs,
                        input string tag);
        int done_at = 0;
        int ndone   = 0;
        int cs_bad  = 0;
        check({tag, "_idle_clk"}, 32'(bus3.sd_clk), 32'd1);
        bus3.data_in = d;
        bus3.cs_sel  = sel;
        bus3.start   = 1'b1;
        for (int n = 1; n <= 39; n++) begin
            @(negedge clk);
            bus3.start = 1'b0;
            if (bus3.done) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (n < 37 && bus3.sd_cs !== exp_cs) cs_bad++;
        end
        check({tag, "_done_cycle"}, 32'(done_at), 32'd37);
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_cs_during"}, 32'(cs_bad), 32'd0);
        check({tag, "_clk_after"}, 32'(bus3.sd_clk), 32'd1);
        check({tag, "_cs_after"}, 32'(bus3.sd_cs), 32'h7);
    endtask

    initial begin
        int ndone;
        rst          = 1'b1;
        hold0        = 1'b0;
        bus0.start   = 1'b0;
        bus0.data_in = 8'h00;
        bus0.cs_sel  = 2'd0;
        bus3.start   = 1'b0;
        bus3.data_in = 8'h00;
        bus3.cs_sel  = 2'd0;
        slv_tx       = 8'h3C;
        slv_rx       = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_clk0", 32'(bus0.sd_clk), 32'd0);
        check("rst_mosi0", 32'(bus0.sd_in), 32'd1);
        check("rst_cs0", 32'(bus0.sd_cs), 32'hF);
        check("rst_busy0", 32'(bus0.busy), 32'd0);
        check("rst_done0", 32'(bus0.done), 32'd0);
        check("rst_dout0", 32'(bus0.data_out), 32'd0);
        check("rst_clk3", 32'(bus3.sd_clk), 32'd1);
        check("rst_cs3", 32'(bus3.sd_cs), 32'h7);
        rst = 1'b0;
        @(negedge clk);

        run0(8'hA5, 2'd0, 1'b0, 1'b0, 37, 4'b1110, 4'b1111, "m0");
        run0(8'h5A, 2'd2, 1'b0, 1'b1, 37, 4'b1011, 4'b1111, "cs2_restart");

        bus0.data_in = 8'h33;
        bus0.cs_sel  = 2'd1;
        bus0.start   = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (n == 10) rst = 1'b1;
        end
        check("midrst_cs", 32'(bus0.sd_cs), 32'hF);
        check("midrst_clk", 32'(bus0.sd_clk), 32'd0);
        check("midrst_busy", 32'(bus0.busy), 32'd0);
        check("midrst_done", 32'(bus0.done), 32'd0);
        check("midrst_dout", 32'(bus0.data_out), 32'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus0.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run0(8'h96, 2'd3, 1'b0, 1'b0, 37, 4'b0111, 4'b1111, "after_rst");

        run3(8'hC3, 2'd0, 3'b110, "m3");
        check("m3_data_out", 32'(bus3.data_out), 32'h3C);
        check("m3_slave_rx", 32'(slv_rx), 32'hC3);
        run3(8'h81, 2'd3, 3'b111, "cs_oor");

`ifdef SPI_CS_HOLD_EN
        run0(8'hA5, 2'd1, 1'b1, 1'b0, 37, 4'b1101, 4'b1101, "hold1");
        run0(8'h3C, 2'd1, 1'b0, 1'b0, 35, 4'b1101, 4'b1111, "hold2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
